// File: rtl/md_issue_ctrl_if.sv
// Bus between the MD issue controller and the multiply/divide unit.
// The controller is the master; the unit answers with Busy and its HI/LO registers.
interface md_issue_ctrl_if;
  logic [3:0]  md_ctrl;
  logic [31:0] md_d1;
  logic [31:0] md_d2;
  logic        md_busy;
  logic [31:0] md_hi;
  logic [31:0] md_lo;

  modport master (
    output md_ctrl, md_d1, md_d2,
    input  md_busy, md_hi, md_lo
  );

  modport slave (
    input  md_ctrl, md_d1, md_d2,
    output md_busy, md_hi, md_lo
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: registers operands, pulses MDCtrl
// for one cycle, follows the Busy handshake and stalls the pipeline while an MD op must wait.
module md_issue_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  input  logic [3:0]            op,
  input  logic [31:0]           rs_data,
  input  logic [31:0]           rt_data,
  input  logic                  flush,
  md_issue_ctrl_if.master       md,
  output logic                  stall,
  output logic [31:0]           mf_data,
  output logic                  mf_valid,
  output logic                  err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitStart, StWaitDone} state_e;

  localparam logic [3:0]       CtrlNop = 4'hF;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             md_op;
  logic             accept;
  logic             timeout;

  // Codes 8-15 are not MD ops at all.
  assign md_op   = op_valid & ~op[3];
  assign accept  = (state == StIdle) & ~md.md_busy & ~flush & md_op;
  assign stall   = reset & md_op & ~flush & ~accept;
  assign timeout = (cnt == CntLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      cnt        <= '0;
      md.md_ctrl <= CtrlNop;
      md.md_d1   <= '0;
      md.md_d2   <= '0;
      mf_data    <= '0;
      mf_valid   <= 1'b0;
      err        <= 1'b0;
    end else begin
      mf_valid <= 1'b0;
      if (flush) begin
        state      <= StIdle;
        md.md_ctrl <= CtrlNop;
        cnt        <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            if (accept) begin
              if (op[2:1] == 2'b11) begin
                // MFHI/MFLO are served locally without touching the unit.
                mf_data  <= op[0] ? md.md_lo : md.md_hi;
                mf_valid <= 1'b1;
              end else begin
                md.md_ctrl <= op;
                md.md_d1   <= rs_data;
                md.md_d2   <= rt_data;
                state      <= StIssue;
              end
            end
          end
          StIssue: begin
            md.md_ctrl <= CtrlNop;
            cnt        <= '0;
            // MULT/DIV/MULTU/DIVU (0-3) run multi-cycle; MTHI/MTLO complete here.
            state      <= (md.md_ctrl[2] == 1'b0) ? StWaitStart : StIdle;
          end
          StWaitStart: begin
            cnt <= cnt + 1'b1;
            if (timeout) begin
              state <= StIdle;
              err   <= 1'b1;
            end else if (md.md_busy) begin
              state <= StWaitDone;
            end
          end
          StWaitDone: begin
            cnt <= cnt + 1'b1;
            if (timeout) begin
              state <= StIdle;
              err   <= 1'b1;
            end else if (!md.md_busy) begin
              state <= StIdle;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: a behavioural MD unit plus a timeline model that predicts, per op,
// the acceptance cycle, the MDCtrl pulse, HI/LO read data and the sticky timeout flag.
module tb_md_issue_ctrl;
  localparam int unsigned TIMEOUT = 16;
  localparam int          Never   = 1 << 30;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] mf_data;
  logic        mf_valid;
  logic        err;

  md_issue_ctrl_if bus ();

  md_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .flush    (flush),
    .md       (bus),
    .stall    (stall),
    .mf_data  (mf_data),
    .mf_valid (mf_valid),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // {HI, LO} produced by each multiply/divide op.
  function automatic logic [63:0] md_calc(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [31:0] q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    q = '0;
    r = '0;
    case (o)
      4'd0: return 64'(sa * sb);
      4'd1: begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); return {r, q}; end
      4'd2: return {32'd0, a} * {32'd0, b};
      4'd3: begin q = a / b; r = a % b; return {r, q}; end
      default: return '0;
    endcase
  endfunction

  // Behavioural multiply/divide unit.
  logic        unit_busy;
  logic        force_busy = 1'b0;
  logic        unit_tied0 = 1'b0;
  logic [31:0] unit_hi, unit_lo;
  logic [63:0] unit_res;
  int          unit_cnt;
  int          busy_len = 3;
  int          next_b = 3;

  assign bus.md_busy = unit_busy | force_busy;
  assign bus.md_hi   = unit_hi;
  assign bus.md_lo   = unit_lo;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      unit_busy <= 1'b0;
      unit_cnt  <= 0;
      unit_hi   <= '0;
      unit_lo   <= '0;
      unit_res  <= '0;
    end else if (unit_cnt != 0) begin
      unit_cnt <= unit_cnt - 1;
      if (unit_cnt == 1) begin
        unit_busy          <= 1'b0;
        {unit_hi, unit_lo} <= unit_res;
      end
    end else if (bus.md_ctrl <= 4'd3 && !unit_tied0) begin
      unit_res  <= md_calc(bus.md_ctrl, bus.md_d1, bus.md_d2);
      unit_cnt  <= busy_len;
      unit_busy <= 1'b1;
    end else if (bus.md_ctrl == 4'd4) begin
      unit_hi <= bus.md_d1;
    end else if (bus.md_ctrl == 4'd5) begin
      unit_lo <= bus.md_d1;
    end
  end

  // Timeline reference model.
  int          cyc = 0;
  int          free_at, busy_end, err_cyc, issue_cyc, mf_cyc;
  logic [3:0]  iss_op;
  logic [31:0] iss_a, iss_b, exp_d1, exp_d2, mhi, mlo, mf_exp;

  function automatic void model_reset();
    free_at = 0; busy_end = 0; err_cyc = Never; issue_cyc = -1; mf_cyc = -1;
    iss_op = 4'hF; iss_a = '0; iss_b = '0; exp_d1 = '0; exp_d2 = '0;
    mhi = '0; mlo = '0; mf_exp = '0;
  endfunction

  function automatic void model_accept(input logic [3:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
    if (o <= 4'd5) begin
      issue_cyc = cyc + 1; iss_op = o; iss_a = a; iss_b = b;
    end
    if (o <= 4'd3) begin
      if (unit_tied0) begin
        free_at = cyc + 2 + int'(TIMEOUT);
        if (err_cyc == Never) err_cyc = free_at;
      end else begin
        busy_len = next_b;
        busy_end = cyc + 2 + busy_len;
        free_at  = cyc + 3 + busy_len;
        {mhi, mlo} = md_calc(o, a, b);
      end
    end else if (o == 4'd4) begin
      free_at = cyc + 2; mhi = a;
    end else if (o == 4'd5) begin
      free_at = cyc + 2; mlo = a;
    end else begin
      free_at = cyc + 1; mf_cyc = cyc + 1; mf_exp = (o == 4'd6) ? mhi : mlo;
    end
  endfunction

  // One clock cycle: drive inputs, check every output at negedge, advance the model.
  task automatic step(input logic v, input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic f, output logic acc, output logic st);
    logic exp_st, is_md;
    logic [3:0] exp_ctrl;
    op_valid = v; op = o; rs_data = a; rt_data = b; flush = f;
    is_md  = v && (o <= 4'd7);
    acc    = is_md && !f && (cyc >= free_at) && (cyc >= busy_end);
    exp_st = is_md && !f && !acc;
    @(negedge clk);
    if (cyc == issue_cyc) begin exp_d1 = iss_a; exp_d2 = iss_b; end
    exp_ctrl = (cyc == issue_cyc) ? iss_op : 4'hF;
    n_cmp++;
    if (stall !== exp_st) begin
      n_fail++; $display("FAIL stall cyc=%0d op=%0d: got %b want %b", cyc, o, stall, exp_st);
    end
    n_cmp++;
    if (bus.md_ctrl !== exp_ctrl) begin
      n_fail++; $display("FAIL md_ctrl cyc=%0d: got %0d want %0d", cyc, bus.md_ctrl, exp_ctrl);
    end
    n_cmp++;
    if ({bus.md_d1, bus.md_d2} !== {exp_d1, exp_d2}) begin
      n_fail++;
      $display("FAIL operands cyc=%0d: got %h/%h want %h/%h", cyc, bus.md_d1, bus.md_d2,
               exp_d1, exp_d2);
    end
    n_cmp++;
    if (mf_valid !== (cyc == mf_cyc)) begin
      n_fail++; $display("FAIL mf_valid cyc=%0d: got %b want %b", cyc, mf_valid, cyc == mf_cyc);
    end
    if (cyc == mf_cyc) begin
      n_cmp++;
      if (mf_data !== mf_exp) begin
        n_fail++; $display("FAIL mf_data cyc=%0d: got %h want %h", cyc, mf_data, mf_exp);
      end
    end
    n_cmp++;
    if (err !== (cyc >= err_cyc)) begin
      n_fail++; $display("FAIL err cyc=%0d: got %b want %b", cyc, err, cyc >= err_cyc);
    end
    st = stall;
    if (acc) model_accept(o, a, b);
    if (f) begin
      free_at = cyc + 1;
      if (err_cyc > cyc && err_cyc != Never) err_cyc = Never;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present one op until the model accepts it; returns the stall cycles the DUT showed.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int dut_stalls);
    logic acc, st;
    acc = 1'b0;
    dut_stalls = 0;
    for (int k = 0; k < 64 && !acc; k++) begin
      step(1'b1, o, a, b, 1'b0, acc, st);
      if (st) dut_stalls++;
    end
  endtask

  task automatic idle(input int n);
    logic acc, st;
    for (int k = 0; k < n; k++) step(1'b0, 4'd0, $urandom, $urandom, 1'b0, acc, st);
  endtask

  task automatic test_reset();
    #1;
    reset = 1'b0; force_busy = 1'b1; op_valid = 1'b1; op = 4'd0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.md_ctrl, stall, err, mf_valid} !== {4'hF, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ctrl=%0d stall=%b err=%b mfv=%b want 15/0/0/0",
               bus.md_ctrl, stall, err, mf_valid);
    end
    n_cmp++;
    if ({bus.md_d1, bus.md_d2, mf_data} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h want zeros", bus.md_d1, bus.md_d2, mf_data);
    end
    reset = 1'b1; force_busy = 1'b0; op_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_mult_mflo();
    int s;
    next_b = 5;
    do_op(4'd0, 32'd7, 32'hFFFFFFFD, s);
    n_cmp++;
    if ({bus.md_ctrl, bus.md_d1, bus.md_d2} !== {4'd0, 32'd7, 32'hFFFFFFFD}) begin
      n_fail++;
      $display("FAIL mult_issue: got %0d %h %h want 0 7 fffffffd", bus.md_ctrl, bus.md_d1,
               bus.md_d2);
    end
    do_op(4'd7, $urandom, $urandom, s);
    n_cmp++;
    if (s !== 7) begin n_fail++; $display("FAIL mflo_stalls: got %0d want 7", s); end
    n_cmp++;
    if ({mf_valid, mf_data} !== {1'b1, 32'hFFFFFFEB}) begin
      n_fail++; $display("FAIL mflo_data: got %b %h want 1 ffffffeb", mf_valid, mf_data);
    end
    idle(2);
  endtask

  task automatic test_mthi_mfhi();
    int s;
    do_op(4'd4, 32'hDEAD, $urandom, s);
    do_op(4'd6, $urandom, $urandom, s);
    n_cmp++;
    if (s !== 1) begin n_fail++; $display("FAIL mfhi_stalls: got %0d want 1", s); end
    n_cmp++;
    if ({mf_valid, mf_data} !== {1'b1, 32'hDEAD}) begin
      n_fail++; $display("FAIL mfhi_data: got %b %h want 1 0000dead", mf_valid, mf_data);
    end
    idle(2);
  endtask

  task automatic test_flush_idle();
    logic acc, st;
    step(1'b1, 4'd2, 32'h1234, 32'h5678, 1'b1, acc, st);
    n_cmp++;
    if (st !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall: got %b want 0", st); end
    n_cmp++;
    if (bus.md_ctrl !== 4'hF) begin
      n_fail++; $display("FAIL flush_idle_ctrl: got %0d want 15", bus.md_ctrl);
    end
    idle(2);
  endtask

  task automatic test_flush_wait_done();
    logic acc, st;
    int s;
    next_b = 5;
    do_op(4'd1, 32'd100, 32'd7, s);
    idle(2);
    step(1'b1, 4'd7, $urandom, $urandom, 1'b1, acc, st);
    n_cmp++;
    if (st !== 1'b0) begin n_fail++; $display("FAIL flush_wd_stall: got %b want 0", st); end
    n_cmp++;
    if (bus.md_ctrl !== 4'hF) begin
      n_fail++; $display("FAIL flush_wd_ctrl: got %0d want 15", bus.md_ctrl);
    end
    do_op(4'd7, $urandom, $urandom, s);
    n_cmp++;
    if (s !== 3) begin n_fail++; $display("FAIL flush_wd_stalls: got %0d want 3", s); end
    n_cmp++;
    if (mf_data !== 32'd14) begin
      n_fail++; $display("FAIL flush_wd_quot: got %h want 0000000e", mf_data);
    end
    idle(2);
  endtask

  task automatic test_random();
    logic acc, st;
    int s;
    logic [3:0] o;
    logic [31:0] b;
    for (int n = 0; n < 80; n++) begin
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        if ($urandom_range(0, 1) == 1)
          step(1'b1, 4'(8 + $urandom_range(0, 7)), $urandom, $urandom, 1'b0, acc, st);
        else
          step(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom, 1'b0, acc, st);
      end
      o = 4'($urandom_range(0, 7));
      b = $urandom;
      if ((o == 4'd1 || o == 4'd3) && b == 32'd0) b = 32'd1;
      next_b = int'($urandom_range(1, 6));
      do_op(o, $urandom, b, s);
    end
    idle(12);
  endtask

  task automatic test_timeout();
    int s;
    unit_tied0 = 1'b1;
    do_op(4'd0, $urandom, $urandom, s);
    do_op(4'd7, $urandom, $urandom, s);
    n_cmp++;
    if (s !== 17) begin n_fail++; $display("FAIL timeout_stalls: got %0d want 17", s); end
    n_cmp++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", err); end
    idle(4);
    unit_tied0 = 1'b0;
    next_b = 2;
    do_op(4'd2, 32'd9, 32'd9, s);
    idle(8);
    n_cmp++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mult_mflo();
    test_mthi_mfhi();
    test_flush_idle();
    test_flush_wait_done();
    test_random();
    test_timeout();
    test_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
